// File: rtl/l0id_readout_sequencer.sv
// l0id_readout_sequencer
// Queues readout requests and starts one packet build at a time. Each finished
// readout strobes the L0ID hold register so the held ID advances. L0ID reset and
// preset commands are latched and only applied while no packet is being built.
module l0id_readout_sequencer #(
    parameter int RO_ADDR_WIDTH = 8,
    parameter int PEND_LOG2     = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic                     CLK,
    input  logic                     SoftReset,
    input  logic                     ReadReq,
    input  logic                     L0IDResetCmd,
    input  logic                     L0IDPresetCmd,
    input  logic [RO_ADDR_WIDTH-1:0] PreL0IDIn,
    input  logic                     ROBusy,
    input  logic                     RODone,
    output logic                     ROStart,
    output logic                     ROReadStrob,
    output logic                     L0IDReset,
    output logic                     L0IDPreset,
    output logic [RO_ADDR_WIDTH-1:0] PreL0ID,
    output logic [PEND_LOG2:0]       PendingCount,
    output logic                     Overflow,
    output logic                     Timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_START,
        S_WAIT,
        S_ADVANCE
    } state_t;

    localparam logic [PEND_LOG2:0] PEND_FULL = (PEND_LOG2+1)'(1 << PEND_LOG2);
    localparam logic [7:0]         WD_LAST   = 8'(TIMEOUT - 1);

    state_t                   r_state;
    logic                     r_resetPend;
    logic                     r_presetPend;
    logic [RO_ADDR_WIDTH-1:0] r_preL0ID;
    logic [PEND_LOG2:0]       r_pendCount;
    logic                     r_overflow;
    logic                     r_timeout;
    logic [7:0]               r_watchdog;
    logic                     r_roStart;
    logic                     r_roReadStrob;
    logic                     r_l0idReset;
    logic                     r_l0idPreset;

    logic w_cmdPending;
    logic w_enterApply;
    logic w_enterStart;
    logic w_decrement;
    logic w_full;

    // A latched command always takes precedence over starting another readout,
    // and flags are consumed on the edge that moves IDLE into APPLY so that a
    // command arriving during APPLY survives for the next idle slot.
    assign w_cmdPending = r_resetPend | r_presetPend;
    assign w_enterApply = (r_state == S_IDLE) && w_cmdPending;
    assign w_enterStart = (r_state == S_IDLE) && !w_cmdPending &&
                          (r_pendCount != '0) && !ROBusy;
    assign w_decrement  = (r_state == S_START);
    assign w_full       = (r_pendCount == PEND_FULL);

    assign ROStart      = r_roStart;
    assign ROReadStrob  = r_roReadStrob;
    assign L0IDReset    = r_l0idReset;
    assign L0IDPreset   = r_l0idPreset;
    assign PreL0ID      = r_preL0ID;
    assign PendingCount = r_pendCount;
    assign Overflow     = r_overflow;
    assign Timeout      = r_timeout;

    // Latch the most recent L0ID command (preset wins a same-cycle tie) and hold the preset value.
    always_ff @(posedge CLK) begin
        if (SoftReset) begin
            r_resetPend  <= 1'b0;
            r_presetPend <= 1'b0;
            r_preL0ID    <= '0;
        end else if (L0IDPresetCmd) begin
            r_resetPend  <= 1'b0;
            r_presetPend <= 1'b1;
            r_preL0ID    <= PreL0IDIn;
        end else if (L0IDResetCmd) begin
            r_resetPend  <= 1'b1;
            r_presetPend <= 1'b0;
        end else if (w_enterApply) begin
            r_resetPend  <= 1'b0;
            r_presetPend <= 1'b0;
        end
    end

    // Count queued requests; a request at full is dropped unless a start frees a slot that cycle.
    always_ff @(posedge CLK) begin
        if (SoftReset) begin
            r_pendCount <= '0;
            r_overflow  <= 1'b0;
        end else begin
            case ({ReadReq, w_decrement})
                2'b10: begin
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_pendCount <= r_pendCount + 1'b1;
                    end
                end
                2'b01:   r_pendCount <= r_pendCount - 1'b1;
                default: r_pendCount <= r_pendCount;
            endcase
        end
    end

    // Readout sequencing FSM with registered one-cycle pulses and the WAIT watchdog.
    always_ff @(posedge CLK) begin
        if (SoftReset) begin
            r_state       <= S_IDLE;
            r_roStart     <= 1'b0;
            r_roReadStrob <= 1'b0;
            r_l0idReset   <= 1'b0;
            r_l0idPreset  <= 1'b0;
            r_watchdog    <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_roStart     <= 1'b0;
            r_roReadStrob <= 1'b0;
            r_l0idReset   <= 1'b0;
            r_l0idPreset  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_enterApply) begin
                        r_state      <= S_APPLY;
                        r_l0idReset  <= 1'b1;
                        r_l0idPreset <= r_presetPend;
                    end else if (w_enterStart) begin
                        r_state   <= S_START;
                        r_roStart <= 1'b1;
                    end
                end
                S_APPLY: begin
                    r_state <= S_IDLE;
                end
                S_START: begin
                    r_watchdog <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    r_watchdog <= r_watchdog + 8'd1;
                    if (RODone) begin
                        r_state       <= S_ADVANCE;
                        r_roReadStrob <= 1'b1;
                    end else if (r_watchdog == WD_LAST) begin
                        r_state       <= S_ADVANCE;
                        r_roReadStrob <= 1'b1;
                        r_timeout     <= 1'b1;
                    end
                end
                S_ADVANCE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l0id_readout_sequencer.sv
// Testbench for l0id_readout_sequencer: a timestamp-based behavioural model
// predicts every output each cycle, and directed scenarios pin the model with
// hand-computed cycle numbers and values.
module tb_l0id_readout_sequencer;

    localparam int W   = 8;
    localparam int CAP = 16;
    localparam int TMO = 255;

    logic         CLK = 1'b0;
    logic         SoftReset;
    logic         ReadReq;
    logic         L0IDResetCmd;
    logic         L0IDPresetCmd;
    logic [W-1:0] PreL0IDIn;
    logic         ROBusy;
    logic         RODone;
    logic         ROStart;
    logic         ROReadStrob;
    logic         L0IDReset;
    logic         L0IDPreset;
    logic [W-1:0] PreL0ID;
    logic [4:0]   PendingCount;
    logic         Overflow;
    logic         Timeout;

    l0id_readout_sequencer #(
        .RO_ADDR_WIDTH(W),
        .PEND_LOG2(4),
        .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK),
        .SoftReset(SoftReset),
        .ReadReq(ReadReq),
        .L0IDResetCmd(L0IDResetCmd),
        .L0IDPresetCmd(L0IDPresetCmd),
        .PreL0IDIn(PreL0IDIn),
        .ROBusy(ROBusy),
        .RODone(RODone),
        .ROStart(ROStart),
        .ROReadStrob(ROReadStrob),
        .L0IDReset(L0IDReset),
        .L0IDPreset(L0IDPreset),
        .PreL0ID(PreL0ID),
        .PendingCount(PendingCount),
        .Overflow(Overflow),
        .Timeout(Timeout)
    );

    // Free-running 10 ns clock.
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: queue depth, latched commands, and timestamps of the current activity.
    int           mPend;
    bit           mRst, mPre, mOvf, mTmo, mInRO, modelValid;
    logic [W-1:0] mPreVal;
    int           mStartAt, mReadyAt;
    bit           eStart, eStrobe, eReset, ePreset;

    // Responder and event logs.
    bit  doneEn    = 1'b0;
    int  doneDelay = 5;
    int  doneAt    = -1;
    bit  lateDone  = 1'b0;
    int  startQ[$];
    int  strobeQ[$];
    int  resetQ[$];
    bit  presetQ[$];
    int  preValQ[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Predict next-cycle outputs from this cycle's inputs using readout timestamps.
    always @(posedge CLK) begin : modelProc
        int c;
        bit inc, dec;
        c       = cyc;
        eStart  = 1'b0;
        eStrobe = 1'b0;
        eReset  = 1'b0;
        ePreset = 1'b0;
        if (SoftReset) begin
            mPend = 0; mRst = 0; mPre = 0; mOvf = 0; mTmo = 0; mInRO = 0;
            mPreVal = '0; mStartAt = -1; mReadyAt = c + 1; modelValid = 1'b1;
        end else if (modelValid) begin
            dec = mInRO && (c == mStartAt);
            if (!mInRO && c >= mReadyAt) begin
                if (mRst || mPre) begin
                    eReset = 1'b1; ePreset = mPre;
                    mRst = 0; mPre = 0;
                    mReadyAt = c + 2;
                end else if (mPend > 0 && !ROBusy) begin
                    eStart = 1'b1; mInRO = 1'b1; mStartAt = c + 1;
                end
            end else if (mInRO && c > mStartAt) begin
                if (RODone) begin
                    eStrobe = 1'b1; mInRO = 0; mReadyAt = c + 2;
                end else if (c - mStartAt == TMO) begin
                    eStrobe = 1'b1; mTmo = 1'b1; mInRO = 0; mReadyAt = c + 2;
                end
            end
            inc = ReadReq;
            if (inc && !dec) begin
                if (mPend == CAP) mOvf = 1'b1;
                else mPend++;
            end else if (dec && !inc) begin
                mPend--;
            end
            if (L0IDPresetCmd) begin
                mPre = 1'b1; mRst = 1'b0; mPreVal = PreL0IDIn;
            end else if (L0IDResetCmd) begin
                mRst = 1'b1; mPre = 1'b0;
            end
        end
        cyc = c + 1;
    end

    // Packet-builder stand-in: pulses RODone a fixed delay after each ROStart.
    always @(posedge CLK) begin
        #2;
        RODone = (doneEn && cyc == doneAt) || lateDone;
    end

    // Compare every output against the model mid-cycle and log DUT events.
    always @(negedge CLK) begin
        if (modelValid) begin
            checkOutput("ROStart",      32'(ROStart),      32'(eStart));
            checkOutput("ROReadStrob",  32'(ROReadStrob),  32'(eStrobe));
            checkOutput("L0IDReset",    32'(L0IDReset),    32'(eReset));
            checkOutput("L0IDPreset",   32'(L0IDPreset),   32'(ePreset));
            checkOutput("PreL0ID",      32'(PreL0ID),      32'(mPreVal));
            checkOutput("PendingCount", 32'(PendingCount), 32'(mPend));
            checkOutput("Overflow",     32'(Overflow),     32'(mOvf));
            checkOutput("Timeout",      32'(Timeout),      32'(mTmo));
            if (ROStart === 1'b1) begin
                startQ.push_back(cyc);
                doneAt = cyc + doneDelay;
            end
            if (ROReadStrob === 1'b1) strobeQ.push_back(cyc);
            if (L0IDReset === 1'b1) begin
                resetQ.push_back(cyc);
                presetQ.push_back(L0IDPreset);
                preValQ.push_back(int'(PreL0ID));
            end
        end
    end

    task automatic applyStimulus(input bit rr, input bit rc, input bit pc,
                                 input logic [W-1:0] val, input int cycles);
        ReadReq       = rr;
        L0IDResetCmd  = rc;
        L0IDPresetCmd = pc;
        PreL0IDIn     = val;
        repeat (cycles) begin
            @(posedge CLK);
            #1;
        end
        ReadReq       = 1'b0;
        L0IDResetCmd  = 1'b0;
        L0IDPresetCmd = 1'b0;
        PreL0IDIn     = '0;
    endtask

    task automatic applyReset();
        SoftReset = 1'b1;
        applyStimulus(0, 0, 0, '0, 2);
        SoftReset = 1'b0;
        startQ.delete(); strobeQ.delete(); resetQ.delete();
        presetQ.delete(); preValQ.delete();
    endtask

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL time_limit actual=expired required=finished");
        $fatal(1, "[TB] time limit");
    end

    initial begin : stim
        int n;
        SoftReset = 1'b1; ReadReq = 0; L0IDResetCmd = 0; L0IDPresetCmd = 0;
        PreL0IDIn = '0; ROBusy = 0; RODone = 0;
        applyReset();
        checkOutput("reset_pending", 32'(PendingCount), 32'd0);
        checkOutput("reset_outs", 32'({ROStart, ROReadStrob, L0IDReset, L0IDPreset, Overflow, Timeout}), 32'd0);

        // Three requests, RODone five cycles after each start.
        doneEn = 1; doneDelay = 5;
        n = cyc;
        applyStimulus(1, 0, 0, '0, 3);
        applyStimulus(0, 0, 0, '0, 30);
        checkOutput("t1_starts", 32'(startQ.size()), 32'd3);
        checkOutput("t1_start0", 32'(startQ[0]), 32'(n + 2));
        checkOutput("t1_start1", 32'(startQ[1]), 32'(n + 10));
        checkOutput("t1_start2", 32'(startQ[2]), 32'(n + 18));
        checkOutput("t1_strobes", 32'(strobeQ.size()), 32'd3);
        checkOutput("t1_pending", 32'(PendingCount), 32'd0);

        // Seventeen requests while busy: saturate at 16, then drain.
        applyReset();
        doneDelay = 2; ROBusy = 1;
        applyStimulus(1, 0, 0, '0, 17);
        applyStimulus(0, 0, 0, '0, 2);
        checkOutput("t2_full", 32'(PendingCount), 32'd16);
        checkOutput("t2_overflow", 32'(Overflow), 32'd1);
        checkOutput("t2_nostart", 32'(startQ.size()), 32'd0);
        ROBusy = 0;
        applyStimulus(0, 0, 0, '0, 100);
        checkOutput("t2_starts", 32'(startQ.size()), 32'd16);
        checkOutput("t2_strobes", 32'(strobeQ.size()), 32'd16);
        checkOutput("t2_drained", 32'(PendingCount), 32'd0);

        // Preset during WAIT is deferred until after the strobe and before the next start.
        applyReset();
        doneDelay = 5;
        n = cyc;
        applyStimulus(1, 0, 0, '0, 2);
        applyStimulus(0, 0, 0, '0, 2);
        applyStimulus(0, 0, 1, 8'h5A, 1);
        applyStimulus(0, 0, 0, '0, 20);
        checkOutput("t3_strobe0", 32'(strobeQ[0]), 32'(n + 8));
        checkOutput("t3_applies", 32'(resetQ.size()), 32'd1);
        checkOutput("t3_applyAt", 32'(resetQ[0]), 32'(n + 10));
        checkOutput("t3_isPreset", 32'(presetQ[0]), 32'd1);
        checkOutput("t3_value", 32'(preValQ[0]), 32'h5A);
        checkOutput("t3_start1", 32'(startQ[1]), 32'(n + 12));

        // Same-cycle reset and preset while idle: preset wins.
        applyReset();
        n = cyc;
        applyStimulus(0, 1, 1, 8'h33, 1);
        applyStimulus(0, 0, 0, '0, 5);
        checkOutput("t4a_applyAt", 32'(resetQ[0]), 32'(n + 2));
        checkOutput("t4a_isPreset", 32'(presetQ[0]), 32'd1);
        checkOutput("t4a_value", 32'(preValQ[0]), 32'h33);

        // Both commands during WAIT, then a reset command: only the reset is applied.
        resetQ.delete(); presetQ.delete(); preValQ.delete();
        n = cyc;
        applyStimulus(1, 0, 0, '0, 1);
        applyStimulus(0, 0, 0, '0, 2);
        applyStimulus(0, 1, 1, 8'h44, 1);
        applyStimulus(0, 1, 0, '0, 1);
        applyStimulus(0, 0, 0, '0, 15);
        checkOutput("t4b_applies", 32'(resetQ.size()), 32'd1);
        checkOutput("t4b_applyAt", 32'(resetQ[0]), 32'(n + 10));
        checkOutput("t4b_isPreset", 32'(presetQ[0]), 32'd0);
        checkOutput("t4b_value", 32'(preValQ[0]), 32'h44);

        // No RODone: the watchdog forces completion 256 cycles after the start.
        applyReset();
        doneEn = 0;
        n = cyc;
        applyStimulus(1, 0, 0, '0, 1);
        applyStimulus(0, 0, 0, '0, 270);
        checkOutput("t5_start", 32'(startQ[0]), 32'(n + 2));
        checkOutput("t5_strobe", 32'(strobeQ[0]), 32'(n + 258));
        checkOutput("t5_timeout", 32'(Timeout), 32'd1);
        applyStimulus(0, 0, 0, '0, 5);
        checkOutput("t5_sticky", 32'(Timeout), 32'd1);
        applyReset();
        checkOutput("t5_cleared", 32'(Timeout), 32'd0);

        // SoftReset during WAIT with four queued requests aborts cleanly.
        n = cyc;
        applyStimulus(1, 0, 0, '0, 5);
        checkOutput("t6_pending4", 32'(PendingCount), 32'd4);
        SoftReset = 1'b1;
        applyStimulus(0, 0, 0, '0, 1);
        SoftReset = 1'b0;
        checkOutput("t6_outs", 32'({ROStart, ROReadStrob, L0IDReset, L0IDPreset, Overflow, Timeout}), 32'd0);
        checkOutput("t6_pending0", 32'(PendingCount), 32'd0);
        lateDone = 1'b1;
        applyStimulus(0, 0, 0, '0, 1);
        lateDone = 1'b0;
        applyStimulus(0, 0, 0, '0, 10);
        checkOutput("t6_nostrobe", 32'(strobeQ.size()), 32'd0);
        checkOutput("t6_starts", 32'(startQ.size()), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
